// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable block RAM with clear sequencer.
// lane_merge combines two words lane by lane under a lane-enable mask.
package bram_pkg;

    localparam int RDW_OLD   = 0;
    localparam int RDW_NEW   = 1;
    localparam int MAX_DBITS = 64;
    localparam int MAX_LANES = 8;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    // Words are zero-extended to MAX_DBITS; only the low dbits of the result are meaningful.
    function automatic logic [MAX_DBITS-1:0] lane_merge(
        input logic [MAX_DBITS-1:0] old_word,
        input logic [MAX_DBITS-1:0] new_word,
        input logic [MAX_LANES-1:0] be,
        input int                   lanes,
        input int                   dbits
    );
        logic [MAX_DBITS-1:0] mask;
        logic [MAX_DBITS-1:0] lane_ones;
        logic [MAX_LANES-1:0] be_sh;
        int                   lw;
        lw        = dbits / lanes;
        lane_ones = (MAX_DBITS'(1) << lw) - MAX_DBITS'(1);
        mask      = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            be_sh = be >> l;
            if (l < lanes && be_sh[0]) begin
                mask = mask | (lane_ones << (l * lw));
            end
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/bram_be_core.sv
// Bare inferable simple-dual-port array with per-lane write enables.
// Registered read with old-data semantics on a same-address collision.
module bram_be_core #(
    parameter int ABITS = 8,
    parameter int DBITS = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic [LANES-1:0] wbe,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata
);

    localparam int LW = DBITS / LANES;

    logic [DBITS-1:0] mem [2**ABITS];

    // NOTE: the array has no reset; a reset would stop it mapping onto block RAM.
    // Deterministic contents come from the clear sequencer in the top level instead.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we && wbe[l]) begin
                mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port RAM with lane enables, read-during-write bypass, optional
// output register, read-valid flag and a post-reset clear sequencer.
module bram_sdp_clr
    import bram_pkg::*;
#(
    parameter int               ABITS     = 8,
    parameter int               DBITS     = 16,
    parameter int               LANES     = 2,
    parameter int               RDW_MODE  = 0,
    parameter int               OUT_REG   = 0,
    parameter logic [DBITS-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic [LANES-1:0] wr_be,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [ABITS-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch,
    // and blocking '=' is used here while clocked state uses non-blocking '<='.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = READY;
            end
        end
    end

    logic clearing, wr_accept, rd_accept;
    assign clearing  = (state_q == CLEAR);
    assign busy      = clearing;
    assign wr_accept = resetn && !clearing && wr_en;
    assign rd_accept = resetn && !clearing && rd_en;

    logic             core_we;
    logic [ABITS-1:0] core_waddr;
    logic [DBITS-1:0] core_wdata, core_rdata;
    logic [LANES-1:0] core_wbe;

    // Memory is left untouched on the reset edge itself.
    assign core_we    = resetn && (clearing || wr_en);
    assign core_waddr = clearing ? clr_ptr_q : wr_addr;
    assign core_wdata = clearing ? CLEAR_VAL : wr_data;
    assign core_wbe   = clearing ? '1 : wr_be;

    bram_be_core #(
        .ABITS (ABITS),
        .DBITS (DBITS),
        .LANES (LANES)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .wbe   (core_wbe),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    logic             v1_q, v2_q, byp_hit_q;
    logic [DBITS-1:0] byp_data_q, hold_q, stage1_data;
    logic [LANES-1:0] byp_be_q;
    logic [MAX_DBITS-1:0] merged;

    // Core returns the pre-write word; write-through mode overlays the captured write lanes.
    assign merged      = lane_merge(MAX_DBITS'(core_rdata), MAX_DBITS'(byp_data_q),
                                    MAX_LANES'(byp_be_q), LANES, DBITS);
    assign stage1_data = byp_hit_q ? merged[DBITS-1:0] : core_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
            hold_q     <= '0;
        end else begin
            v1_q       <= rd_accept;
            v2_q       <= v1_q;
            byp_hit_q  <= rd_accept && wr_accept && (rd_addr == wr_addr) && (RDW_MODE == RDW_NEW);
            byp_data_q <= wr_data;
            byp_be_q   <= wr_be;
            if (v1_q) begin
                hold_q <= stage1_data;
            end
        end
    end

    // hold_q doubles as the output register when OUT_REG is set.
    generate
        if (OUT_REG != 0) begin : g_out_reg
            assign rd_data  = hold_q;
            assign rd_valid = v2_q;
        end else begin : g_out_direct
            assign rd_data  = v1_q ? stage1_data : hold_q;
            assign rd_valid = v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Directed bench: two instances (old-data/latency 1 and write-through/latency 2)
// share one stimulus stream; expected values are hand-computed.
module tb_bram_sdp_clr;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, busy0, busy1;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [15:0] CV = 16'hA5A5;

    always #5 clk = ~clk;

    bram_sdp_clr #(
        .ABITS(4), .DBITS(16), .LANES(2), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)
    ) dut0 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .busy(busy0)
    );

    bram_sdp_clr #(
        .ABITS(4), .DBITS(16), .LANES(2), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VAL(CV)
    ) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    // Single read: dut0 answers one edge after sampling, dut1 one edge later.
    task automatic rd_chk(input logic [3:0] a, input logic [15:0] e);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check($sformatf("rd%0d dut0 valid", a), 16'(rd_valid0), 16'd1);
        check($sformatf("rd%0d dut0 data", a), rd_data0, e);
        check($sformatf("rd%0d dut1 early valid", a), 16'(rd_valid1), 16'd0);
        tick();
        check($sformatf("rd%0d dut0 valid drop", a), 16'(rd_valid0), 16'd0);
        check($sformatf("rd%0d dut0 hold", a), rd_data0, e);
        check($sformatf("rd%0d dut1 valid", a), 16'(rd_valid1), 16'd1);
        check($sformatf("rd%0d dut1 data", a), rd_data1, e);
    endtask

    // Counts edges until each busy falls; 0 means it never fell within the bound.
    task automatic count_clear(input string tag, input logic reqs);
        int n0 = 0;
        int n1 = 0;
        for (int n = 1; n <= 40; n++) begin
            wr_en = reqs; wr_addr = 4'd7; wr_data = 16'hDEAD; wr_be = 2'b11;
            rd_en = reqs; rd_addr = 4'd7;
            tick();
            if (!busy0 && n0 == 0) n0 = n;
            if (!busy1 && n1 == 0) n1 = n;
            if (busy0) check($sformatf("%s valid0 n%0d", tag, n), 16'(rd_valid0), 16'd0);
            if (busy1) check($sformatf("%s valid1 n%0d", tag, n), 16'(rd_valid1), 16'd0);
            if (n0 != 0 && n1 != 0) break;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check({tag, " busy edges dut0"}, 16'(n0), 16'd16);
        check({tag, " busy edges dut1"}, 16'(n1), 16'd16);
    endtask

    function automatic logic [15:0] stream_word(input int i);
        logic [3:0] a;
        a = 4'(i);
        return {a, ~a, a ^ 4'h5, 4'hC};
    endfunction

    initial begin
        resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) tick();
        check("reset busy0", 16'(busy0), 16'd1);
        check("reset busy1", 16'(busy1), 16'd1);
        check("reset valid0", 16'(rd_valid0), 16'd0);
        check("reset valid1", 16'(rd_valid1), 16'd0);
        check("reset data0", rd_data0, 16'h0000);
        check("reset data1", rd_data1, 16'h0000);

        // Clear with user requests hammering address 7 every edge.
        resetn = 1'b1;
        count_clear("clr1", 1'b1);
        check("clr1 data0 held", rd_data0, 16'h0000);
        check("clr1 data1 held", rd_data1, 16'h0000);
        rd_chk(4'd7, CV);
        for (int i = 0; i < 16; i++) rd_chk(4'(i), CV);

        // Lane-enable write.
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hBEEF, 2'b10);
        rd_chk(4'd3, 16'hBE34);
        wr(4'd3, 16'h5678, 2'b00);
        rd_chk(4'd3, 16'hBE34);

        // Same-address read during write.
        wr(4'd5, 16'h0000, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hCAFE; wr_be = 2'b01;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw dut0 valid", 16'(rd_valid0), 16'd1);
        check("rdw dut0 old data", rd_data0, 16'h0000);
        tick();
        check("rdw dut1 valid", 16'(rd_valid1), 16'd1);
        check("rdw dut1 new data", rd_data1, 16'h00FE);
        rd_chk(4'd5, 16'h00FE);

        // Different-address read during write.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h1111; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw diff dut0", rd_data0, CV);
        tick();
        check("rdw diff dut1", rd_data1, CV);
        rd_chk(4'd6, 16'h1111);

        // Reset mid-clear at step 9.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (9) tick();
        check("mid busy0", 16'(busy0), 16'd1);
        resetn = 1'b0;
        tick();
        check("mid reset data1", rd_data1, 16'h0000);
        resetn = 1'b1;
        count_clear("clr2", 1'b0);
        for (int i = 0; i < 16; i++) rd_chk(4'(i), CV);

        // Streaming reads of distinct words.
        for (int i = 0; i < 16; i++) wr(4'(i), stream_word(i), 2'b11);
        for (int k = 1; k <= 18; k++) begin
            rd_en = (k <= 16); rd_addr = 4'(k - 1);
            tick();
            check($sformatf("stream k%0d valid0", k), 16'(rd_valid0), 16'(k <= 16));
            check($sformatf("stream k%0d data0", k), rd_data0, stream_word((k <= 16 ? k : 16) - 1));
            check($sformatf("stream k%0d valid1", k), 16'(rd_valid1), 16'(k >= 2 && k <= 17));
            if (k >= 2)
                check($sformatf("stream k%0d data1", k), rd_data1, stream_word((k <= 17 ? k : 17) - 2));
        end
        rd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
